// File: rtl/display.sv
// display: 24-hour clock core with a 1 s prescaler, 1 Hz blink and synchronous time load
// Ports: clk (system clock), reset (async, active-low), set (load strobe),
//        set_hours[4:0] / set_minutes[6:0] (load values), sec (1 Hz blink),
//        min[6:0] (minutes 0..59), hrs[4:0] (hours 0..23)
module display #(
    parameter int CLKS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic [4:0] set_hours,
    input  logic [6:0] set_minutes,
    output logic       sec,
    output logic [6:0] min,
    output logic [4:0] hrs
);
    localparam int PW = $clog2(CLKS_PER_SEC);
    logic [PW-1:0] pre, pre_nx;
    logic [5:0] s, s_nx;
    logic [6:0] min_nx;
    logic [4:0] hrs_nx;
    logic tick, load, m_wrap, h_wrap;
    always_comb begin
        tick   = pre == PW'(CLKS_PER_SEC - 1);
        load   = set && set_hours <= 5'd23 && set_minutes <= 7'd59;
        m_wrap = tick && s == 6'd59;
        h_wrap = m_wrap && min == 7'd59;
        pre_nx = (load || tick) ? '0 : pre + 1'b1;
        s_nx   = load ? 6'd0 : tick ? (s == 6'd59 ? 6'd0 : s + 6'd1) : s;
        min_nx = load ? set_minutes : m_wrap ? (min == 7'd59 ? 7'd0 : min + 7'd1) : min;
        hrs_nx = load ? set_hours : h_wrap ? (hrs == 5'd23 ? 5'd0 : hrs + 5'd1) : hrs;
    end
    // sec is derived from the next prescaler value so it always mirrors pre >= half
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            s   <= '0;
            min <= '0;
            hrs <= '0;
            sec <= 1'b0;
        end else begin
            pre <= pre_nx;
            s   <= s_nx;
            min <= min_nx;
            hrs <= hrs_nx;
            sec <= pre_nx >= PW'(CLKS_PER_SEC / 2);
        end
    end
endmodule

// File: tb/tb_display.sv
// tb_display: self-checking bench for display with CLKS_PER_SEC=10
module tb_display;
    localparam int CPS = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic set = 1'b0;
    logic [4:0] set_hours = '0;
    logic [6:0] set_minutes = '0;
    logic sec;
    logic [6:0] min;
    logic [4:0] hrs;
    int errors = 0;
    int checks = 0;
    typedef struct {
        string name;
        logic [4:0] h;
        logic [6:0] m;
        logic s;
    } exp_t;
    typedef struct {
        string name;
        bit set;
        logic [4:0] sh;
        logic [6:0] sm;
        int cycles;
        logic [4:0] eh;
        logic [6:0] em;
        logic es;
    } vec_t;
    exp_t sb[$];
    vec_t vt[12];
    display #(.CLKS_PER_SEC(CPS)) dut (
        .clk(clk),
        .reset(reset),
        .set(set),
        .set_hours(set_hours),
        .set_minutes(set_minutes),
        .sec(sec),
        .min(min),
        .hrs(hrs)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic push(input string name, input logic [4:0] h, input logic [6:0] m, input logic s);
        sb.push_back('{name, h, m, s});
    endtask
    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({hrs, min, sec} !== {e.h, e.m, e.s}) begin
            errors++;
            $display("FAIL %s: got hrs=%0d min=%0d sec=%0b, expected hrs=%0d min=%0d sec=%0b",
                     e.name, hrs, min, sec, e.h, e.m, e.s);
        end
    endtask
    task automatic check_s(input string name, input int es);
        checks++;
        if (int'(dut.s) != es) begin
            errors++;
            $display("FAIL %s: got s=%0d, expected s=%0d", name, dut.s, es);
        end
    endtask
    initial begin
        vt[0]  = '{"set_12_30",       1, 12, 30,   1, 12, 30, 0};
        vt[1]  = '{"run_one_minute",  0,  0,  0, 600, 12, 31, 0};
        vt[2]  = '{"half_second",     0,  0,  0,   5, 12, 31, 1};
        vt[3]  = '{"bad_hours_24",    1, 24, 10,   3, 12, 31, 1};
        vt[4]  = '{"bad_minutes_60",  1,  5, 60,   2, 12, 31, 0};
        vt[5]  = '{"bad_both",        1, 31, 70,   1, 12, 31, 0};
        vt[6]  = '{"set_23_59",       1, 23, 59,   1, 23, 59, 0};
        vt[7]  = '{"pre_day_wrap",    0,  0,  0, 599, 23, 59, 1};
        vt[8]  = '{"day_wrap",        0,  0,  0,   1,  0,  0, 0};
        vt[9]  = '{"to_pre_9",        0,  0,  0,   9,  0,  0, 1};
        vt[10] = '{"set_over_tick",   1,  1,  2,   1,  1,  2, 0};
        vt[11] = '{"minute_after_set",0,  0,  0, 600,  1,  3, 0};
        reset = 1'b0;
        cyc(5);
        push("reset_hold", 0, 0, 0);
        compare();
        reset = 1'b1;
        push("sec_rise", 0, 0, 1);
        cyc(5);
        compare();
        push("sec_fall", 0, 0, 0);
        cyc(5);
        compare();
        check_s("s_after_1s", 1);
        push("one_minute", 0, 1, 0);
        cyc(590);
        compare();
        push("one_hour", 1, 0, 0);
        cyc(35400);
        compare();
        for (int i = 0; i < 12; i++) begin
            set = vt[i].set;
            set_hours = vt[i].sh;
            set_minutes = vt[i].sm;
            push(vt[i].name, vt[i].eh, vt[i].em, vt[i].es);
            cyc(1);
            set = 1'b0;
            cyc(vt[i].cycles - 1);
            compare();
            if (i == 10) check_s("s_after_set_over_tick", 0);
        end
        set = 1'b1;
        set_hours = 7;
        set_minutes = 45;
        push("set_held", 7, 45, 0);
        cyc(4);
        compare();
        set = 1'b0;
        push("after_held", 7, 45, 1);
        cyc(5);
        compare();
        check_s("s_after_held", 0);
        set = 1'b1;
        set_hours = 12;
        set_minutes = 30;
        cyc(1);
        set = 1'b0;
        cyc(3);
        @(posedge clk);
        #2 reset = 1'b0;
        push("async_reset", 0, 0, 0);
        #1 compare();
        check_s("s_async_reset", 0);
        set = 1'b1;
        push("set_during_reset", 0, 0, 0);
        cyc(2);
        compare();
        set = 1'b0;
        reset = 1'b1;
        push("rerelease", 0, 0, 1);
        cyc(5);
        compare();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
